// File: rtl/mc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with memory-stall timeout and trap handling.
// Optional sticky interrupt support is enabled by defining MC_SEQUENCER_IRQ_EN.
module mc_sequencer #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h8000_0000),
   parameter int              MEM_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ready,
   output logic            instr_valid,
   input  logic            dec_exc,
   input  logic            dec_is_mem,
   input  logic            dec_is_store,
   input  logic            dec_reg_write,
   input  logic            dec_mret,
   output logic            alu_start,
   input  logic            alu_done,
   input  logic [XLEN-1:0] alu_result,
   input  logic            take_jump,
   input  logic [XLEN-1:0] jump_target,
   input  logic            irq,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   output logic            rf_we,
   output logic            trap,
   output logic [3:0]      trap_cause,
   output logic            trap_is_irq,
   output logic [XLEN-1:0] pc,
   output logic [2:0]      stage
);

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, WAIT_ALU, MEM, WB, NEXT_PC, TRAP
   } stateT;

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   stateT            state, stateNext;
   logic [XLEN-1:0]  pcQ, pcNext;
   logic [XLEN-1:0]  addrQ, addrNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [3:0]       causeQ, causeNext;
   logic             stall, expire, irqPending;

   assign stall  = ((state == FETCH) || (state == MEM)) && !mem_ready;
   assign expire = (MEM_TIMEOUT != 0) && stall && (cnt == CNT_W'(MEM_TIMEOUT - 1));

`ifdef MC_SEQUENCER_IRQ_EN
   logic irqPend;

   // Pending bit is dropped in the cycle NEXT_PC hands it to TRAP.
   always_ff @(posedge clk) begin
      if (rst)
         irqPend <= 1'b0;
      else if (state == NEXT_PC && irqPend)
         irqPend <= 1'b0;
      else
         irqPend <= irqPend | irq;
   end
   assign irqPending = irqPend;
`else
   logic unusedIrq;
   assign unusedIrq  = irq;
   assign irqPending = 1'b0;
`endif

   // NOTE: rst is synchronous, so it is tested inside the clocked branch and kept out of the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= FETCH;
         pcQ    <= RESET_PC;
         addrQ  <= '0;
         cnt    <= '0;
         causeQ <= '0;
      end else begin
         state  <= stateNext;
         pcQ    <= pcNext;
         addrQ  <= addrNext;
         cnt    <= cntNext;
         causeQ <= causeNext;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      stateNext = state;
      pcNext    = pcQ;
      addrNext  = addrQ;
      causeNext = causeQ;
      case (state)
         FETCH: begin
            if (mem_ready)
               stateNext = DECODE;
            else if (expire) begin
               stateNext = TRAP;
               causeNext = 4'd1;
            end
         end
         DECODE: begin
            if (dec_exc) begin
               stateNext = TRAP;
               causeNext = 4'd2;
            end else
               stateNext = EXEC;
         end
         EXEC: stateNext = WAIT_ALU;
         WAIT_ALU: begin
            if (alu_done) begin
               addrNext = alu_result;
               if (dec_is_mem)
                  stateNext = MEM;
               else if (dec_reg_write)
                  stateNext = WB;
               else
                  stateNext = NEXT_PC;
            end
         end
         MEM: begin
            if (mem_ready)
               stateNext = dec_is_store ? NEXT_PC : WB;
            else if (expire) begin
               stateNext = TRAP;
               causeNext = dec_is_store ? 4'd7 : 4'd5;
            end
         end
         WB: stateNext = NEXT_PC;
         NEXT_PC: begin
            stateNext = FETCH;
            if (irqPending) begin
               stateNext = TRAP;
               causeNext = 4'd11;
            end else if (dec_mret)
               pcNext = mepc;
            else if (take_jump && (jump_target[1:0] != 2'b00)) begin
               stateNext = TRAP;
               causeNext = 4'd0;
            end else if (take_jump)
               pcNext = jump_target;
            else
               pcNext = pcQ + XLEN'(4);
         end
         TRAP: begin
            pcNext    = mtvec;
            stateNext = FETCH;
         end
         default: stateNext = FETCH;
      endcase
      // Stall count is per-visit: any state change restarts it.
      cntNext = (stall && (stateNext == state)) ? cnt + CNT_W'(1) : '0;
   end

   // Outputs are forced quiet while rst is held, whatever the state register holds.
   always_comb begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      instr_valid = 1'b0;
      alu_start   = 1'b0;
      rf_we       = 1'b0;
      trap        = 1'b0;
      trap_cause  = 4'd0;
      trap_is_irq = 1'b0;
      if (!rst) begin
         case (state)
            FETCH: begin
               mem_req     = 1'b1;
               mem_addr    = pcQ;
               instr_valid = mem_ready;
            end
            EXEC: alu_start = 1'b1;
            MEM: begin
               mem_req  = 1'b1;
               mem_addr = addrQ;
               mem_we   = dec_is_store;
            end
            WB: rf_we = 1'b1;
            TRAP: begin
               trap       = 1'b1;
               trap_cause = causeQ;
`ifdef MC_SEQUENCER_IRQ_EN
               trap_is_irq = (causeQ == 4'd11);
`endif
            end
            default: ;
         endcase
      end
   end

   assign pc    = rst ? RESET_PC : pcQ;
   assign stage = rst ? 3'(FETCH) : 3'(state);

endmodule

// File: tb/tb_mc_sequencer.sv
// Table-driven bench for mc_sequencer: each record runs one instruction end to end
// with hand-computed results; reset and mid-access reset are hand-written sequences.
module tb_mc_sequencer;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] MTVEC    = 32'h8000_0040;
   localparam logic [31:0] MEPC     = 32'h8000_0300;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr;
   logic        instr_valid, dec_exc, dec_is_mem, dec_is_store, dec_reg_write, dec_mret;
   logic        alu_start, alu_done, take_jump, irq;
   logic [31:0] alu_result, jump_target, mtvec, mepc, pc;
   logic        rf_we, trap, trap_is_irq;
   logic [3:0]  trap_cause;
   logic [2:0]  stage;

   always #5 clk = ~clk;

   mc_sequencer #(.XLEN(32), .RESET_PC(RESET_PC), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .instr_valid(instr_valid), .dec_exc(dec_exc), .dec_is_mem(dec_is_mem),
      .dec_is_store(dec_is_store), .dec_reg_write(dec_reg_write), .dec_mret(dec_mret),
      .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
      .take_jump(take_jump), .jump_target(jump_target),
      .irq(irq), .mtvec(mtvec), .mepc(mepc), .rf_we(rf_we), .trap(trap),
      .trap_cause(trap_cause), .trap_is_irq(trap_is_irq), .pc(pc), .stage(stage)
   );

   typedef struct {
      int          fetchStall;
      int          memStall;
      bit          exc, isMem, isStore, regWrite, mret, takeJump, irqPulse;
      logic [31:0] jumpTarget, aluResult;
      logic [31:0] expPc;
      bit          expTrap;
      logic [3:0]  expCause;
      bit          expIrq;
      int          expIv, expAlu, expRf, expMemCyc;
      logic [31:0] expMemAddr;
      bit          expMemWe;
   } vecT;

   int errors = 0;
   int checks = 0;
   vecT vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vecT mk(int fs, int ms, bit exc, bit isMem, bit isStore, bit rw, bit mret,
                              bit tj, bit irqP, logic [31:0] jt, logic [31:0] ar, logic [31:0] ep,
                              bit tr, logic [3:0] ca, bit ir, int iv, int alu, int rf, int mc,
                              logic [31:0] ma, bit mw);
      vecT v;
      v.fetchStall = fs;  v.memStall = ms;
      v.exc = exc;  v.isMem = isMem;  v.isStore = isStore;  v.regWrite = rw;
      v.mret = mret;  v.takeJump = tj;  v.irqPulse = irqP;
      v.jumpTarget = jt;  v.aluResult = ar;  v.expPc = ep;
      v.expTrap = tr;  v.expCause = ca;  v.expIrq = ir;
      v.expIv = iv;  v.expAlu = alu;  v.expRf = rf;  v.expMemCyc = mc;
      v.expMemAddr = ma;  v.expMemWe = mw;
      return v;
   endfunction

   // Drives one instruction from FETCH back to the next FETCH, acting as memory, decoder and ALU.
   task automatic runVec(input int idx, input vecT v);
      int          fs = 0, ms = 0, aw = 0, rfCnt = 0, ivCnt = 0, aluCnt = 0, memCyc = 0;
      bit          left = 0, done = 0, trapSeen = 0, irqSeen = 0;
      bit          idleOk = 1, causeOk = 1, rfOk = 1, memWeSeen = 0;
      logic [3:0]  cause = 4'd0;
      logic [31:0] memAddrSeen = 32'd0;
      string       p;
      p = $sformatf("v%0d", idx);
      dec_exc = v.exc;  dec_is_mem = v.isMem;  dec_is_store = v.isStore;
      dec_reg_write = v.regWrite;  dec_mret = v.mret;  take_jump = v.takeJump;
      jump_target = v.jumpTarget;  alu_result = v.aluResult;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (left && stage == 3'd0) begin
            done = 1;
            break;
         end
         mem_ready = 1'b0;  alu_done = 1'b0;  irq = 1'b0;
         case (stage)
            3'd0: begin mem_ready = (fs == v.fetchStall); fs++; end
            3'd3: begin alu_done = (aw == 1); irq = (aw == 0) && v.irqPulse; aw++; end
            3'd4: begin mem_ready = (ms == v.memStall); ms++; end
            default: ;
         endcase
         if (stage != 3'd0) left = 1;
         #1;
         if (stage == 3'd4) begin memCyc++; memAddrSeen = mem_addr; memWeSeen = mem_we; end
         if (instr_valid) ivCnt++;
         if (alu_start) aluCnt++;
         if (rf_we) begin rfCnt++; if (stage != 3'd5) rfOk = 0; end
         if (!mem_req && (mem_addr != 32'd0 || mem_we)) idleOk = 0;
         if (trap) begin trapSeen = 1; cause = trap_cause; irqSeen = trap_is_irq; end
         else if (trap_cause != 4'd0 || trap_is_irq) causeOk = 0;
         @(negedge clk);
      end
      check({p, " back-to-fetch"}, 32'(done), 32'd1);
      check({p, " next fetch addr"}, mem_addr, v.expPc);
      check({p, " pc"}, pc, v.expPc);
      check({p, " trap"}, 32'(trapSeen), 32'(v.expTrap));
      check({p, " trap_cause"}, 32'(cause), 32'(v.expCause));
      check({p, " trap_is_irq"}, 32'(irqSeen), 32'(v.expIrq));
      check({p, " instr_valid pulses"}, 32'(ivCnt), 32'(v.expIv));
      check({p, " alu_start pulses"}, 32'(aluCnt), 32'(v.expAlu));
      check({p, " rf_we pulses"}, 32'(rfCnt), 32'(v.expRf));
      check({p, " mem cycles"}, 32'(memCyc), 32'(v.expMemCyc));
      check({p, " mem addr"}, memAddrSeen, v.expMemAddr);
      check({p, " mem we"}, 32'(memWeSeen), 32'(v.expMemWe));
      check({p, " idle bus quiet"}, 32'(idleOk), 32'd1);
      check({p, " cause zero outside trap"}, 32'(causeOk), 32'd1);
      check({p, " rf_we only in WB"}, 32'(rfOk), 32'd1);
   endtask

   initial begin
      bit reached;
      //                fs  ms exc mem st rw mret tj irq jumpTarget    aluResult     expPc         tr cause irq iv alu rf mc memAddr       we
      vecs[0]  = mk(2,  0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h8000_0004, 0, 4'd0, 0, 1, 1, 0, 0,  32'h0,        0);
      vecs[1]  = mk(0,  3, 0, 1, 0, 1, 0, 0, 0, 32'h0,        32'h8000_0100, 32'h8000_0008, 0, 4'd0, 0, 1, 1, 1, 4,  32'h8000_0100, 0);
      vecs[2]  = mk(0,  0, 0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h8000_0104, 32'h8000_000C, 0, 4'd0, 0, 1, 1, 0, 1,  32'h8000_0104, 1);
      vecs[3]  = mk(0,  0, 0, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0000_1234, 32'h8000_0010, 0, 4'd0, 0, 1, 1, 1, 0,  32'h0,        0);
      vecs[4]  = mk(1,  0, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0102, 32'h0,        MTVEC,         1, 4'd0, 0, 1, 1, 0, 0,  32'h0,        0);
      vecs[5]  = mk(0,  0, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0200, 32'h0,        32'h8000_0200, 0, 4'd0, 0, 1, 1, 0, 0,  32'h0,        0);
      vecs[6]  = mk(0,  0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        MEPC,          0, 4'd0, 0, 1, 1, 0, 0,  32'h0,        0);
      vecs[7]  = mk(1,  0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        MTVEC,         1, 4'd2, 0, 1, 0, 0, 0,  32'h0,        0);
      vecs[8]  = mk(0,  0, 0, 0, 0, 0, 1, 1, 0, 32'h8000_0200, 32'h0,        MEPC,          0, 4'd0, 0, 1, 1, 0, 0,  32'h0,        0);
      vecs[9]  = mk(14, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h8000_0304, 0, 4'd0, 0, 1, 1, 0, 0,  32'h0,        0);
      vecs[10] = mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        MTVEC,         1, 4'd1, 0, 0, 0, 0, 0,  32'h0,        0);
      vecs[11] = mk(0, 14, 0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h8000_0108, 32'h8000_0044, 0, 4'd0, 0, 1, 1, 0, 15, 32'h8000_0108, 1);
      vecs[12] = mk(0, 15, 0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h8000_010C, MTVEC,         1, 4'd7, 0, 1, 1, 0, 15, 32'h8000_010C, 1);
      vecs[13] = mk(0, 15, 0, 1, 0, 1, 0, 0, 0, 32'h0,        32'h8000_0110, MTVEC,         1, 4'd5, 0, 1, 1, 0, 15, 32'h8000_0110, 0);
`ifdef MC_SEQUENCER_IRQ_EN
      vecs[14] = mk(0,  0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        MTVEC,         1, 4'd11, 1, 1, 1, 0, 0, 32'h0,        0);
`else
      vecs[14] = mk(0,  0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h8000_0044, 0, 4'd0, 0, 1, 1, 0, 0,  32'h0,        0);
`endif

      rst = 1'b1;  mem_ready = 1'b0;  dec_exc = 1'b0;  dec_is_mem = 1'b0;  dec_is_store = 1'b0;
      dec_reg_write = 1'b0;  dec_mret = 1'b0;  alu_done = 1'b0;  alu_result = 32'h0;
      take_jump = 1'b0;  jump_target = 32'h0;  irq = 1'b0;  mtvec = MTVEC;  mepc = MEPC;

      repeat (3) @(negedge clk);
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset instr_valid", 32'(instr_valid), 32'd0);
      check("reset alu_start", 32'(alu_start), 32'd0);
      check("reset rf_we", 32'(rf_we), 32'd0);
      check("reset trap", 32'(trap), 32'd0);
      check("reset stage", 32'(stage), 32'd0);
      check("reset pc", pc, RESET_PC);
      rst = 1'b0;
      #1;
      check("release mem_req", 32'(mem_req), 32'd1);
      check("release mem_addr", mem_addr, RESET_PC);

      for (int i = 0; i < 15; i++) runVec(i, vecs[i]);

      // Reset in the middle of a stalled load must abandon it cleanly.
      dec_exc = 1'b0;  dec_is_mem = 1'b1;  dec_is_store = 1'b0;  dec_reg_write = 1'b1;
      dec_mret = 1'b0;  take_jump = 1'b0;  alu_result = 32'h8000_0100;  irq = 1'b0;
      reached = 0;
      for (int c = 0; c < 50; c++) begin
         mem_ready = (stage == 3'd0);
         alu_done  = (stage == 3'd3);
         if (stage == 3'd4) begin
            reached = 1;
            break;
         end
         @(negedge clk);
      end
      check("rst-mid reached MEM", 32'(reached), 32'd1);
      mem_ready = 1'b0;  alu_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst-mid stalled stage", 32'(stage), 32'd4);
      check("rst-mid stalled addr", mem_addr, 32'h8000_0100);
      rst = 1'b1;
      #1;
      check("rst-mid held mem_req", 32'(mem_req), 32'd0);
      check("rst-mid held rf_we", 32'(rf_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst-mid after stage", 32'(stage), 32'd0);
      check("rst-mid after mem_req", 32'(mem_req), 32'd1);
      check("rst-mid after mem_addr", mem_addr, RESET_PC);
      check("rst-mid after rf_we", 32'(rf_we), 32'd0);
      check("rst-mid after trap", 32'(trap), 32'd0);
      check("rst-mid after pc", pc, RESET_PC);

      runVec(15, vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, PC value after reset.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, consecutive stall cycles before access-fault trap; 0 disables the timeout.
REQ-004 SHALL have ports: clk input 1 clock; rst input 1 reset (synchronous, active-high).
REQ-005 SHALL have ports: mem_req output 1 access request; mem_we output 1 write; mem_addr output XLEN address; mem_ready input 1 access complete this cycle.
REQ-006 SHALL have ports: instr_valid output 1 fetched word capture strobe; dec_exc input 1 illegal/ecall/ebreak; dec_is_mem input 1; dec_is_store input 1; dec_reg_write input 1; dec_mret input 1.
REQ-007 SHALL have ports: alu_start output 1; alu_done input 1; alu_result input XLEN; take_jump input 1; jump_target input XLEN.
REQ-008 SHALL have ports: irq input 1; mtvec input XLEN; mepc input XLEN; rf_we output 1; trap output 1; trap_cause output 4; trap_is_irq output 1; pc output XLEN; stage output 3.

Function
REQ-009 SHALL sequence states FETCH=0, DECODE=1, EXEC=2, WAIT_ALU=3, MEM=4, WB=5, NEXT_PC=6, TRAP=7; stage SHALL equal current state.
REQ-010 FETCH: mem_req=1, mem_we=0, mem_addr=pc held until mem_ready; cycle with mem_ready=1 SHALL assert instr_valid and go to DECODE.
REQ-011 DECODE: one cycle; dec_exc=1 -> TRAP cause 2; else EXEC.
REQ-012 EXEC: alu_start=1 for exactly one cycle -> WAIT_ALU.
REQ-013 WAIT_ALU: hold until alu_done; on alu_done latch alu_result into addr_q; dec_is_mem -> MEM, else dec_reg_write -> WB, else NEXT_PC.
REQ-014 MEM: mem_req=1, mem_addr=addr_q, mem_we=dec_is_store, held until mem_ready; then store -> NEXT_PC, load -> WB.
REQ-015 WB: rf_we=1 for exactly one cycle -> NEXT_PC; rf_we SHALL be 0 in every other state.
REQ-016 NEXT_PC priority: pending irq -> TRAP cause 11, trap_is_irq=1; dec_mret -> pc<=mepc; take_jump with jump_target[1:0]!=0 -> TRAP cause 0; take_jump -> pc<=jump_target; else pc<=pc+4 (modulo 2^XLEN); non-trap exits go to FETCH.
REQ-017 TRAP: single cycle; trap=1, trap_cause valid, pc<=mtvec, -> FETCH; trap_cause/trap_is_irq SHALL be 0 outside TRAP.
REQ-018 Timeout: counter counts consecutive cycles with mem_req=1 and mem_ready=0, clears on state exit; at MEM_TIMEOUT such cycles -> TRAP cause 1 (FETCH), 5 (MEM load), 7 (MEM store).
REQ-019 mem_ready=1 in the cycle the counter would expire SHALL win (access completes, no trap).
REQ-020 mem_addr, mem_we SHALL be 0 when mem_req=0.
REQ-021 pc SHALL change only on NEXT_PC exit or TRAP exit.

Reset
REQ-022 While rst=1: state FETCH, pc=RESET_PC, counter=0, addr_q=0, irq pending=0, all strobes (mem_req, instr_valid, alu_start, rf_we, trap) 0.
REQ-023 rst asserted in any state, including mid-access, SHALL abort it; first cycle after release SHALL show mem_req=1, mem_addr=RESET_PC.

Configuration
REQ-024 With MC_SEQUENCER_IRQ_EN defined: irq sampled every cycle into a sticky pending bit, cleared on TRAP entry with cause 11; honoured only in NEXT_PC.
REQ-025 Without MC_SEQUENCER_IRQ_EN: irq ignored, no pending register, trap_is_irq tied 0, cause 11 never produced.

Verification
REQ-026 Reset release, mem_ready=1 after 2 stall cycles, ALU op, no mem, no reg write -> FETCH addr 0x8000_0000, next FETCH addr 0x8000_0004.
REQ-027 Load, alu_result=0x8000_0100, mem_ready after 3 cycles -> mem_addr 0x8000_0100, mem_we=0, one rf_we pulse, then pc+4.
REQ-028 mem_ready held 0 in MEM on store with MEM_TIMEOUT=15 -> trap after 15 stall cycles, cause 7, next fetch at mtvec=0x8000_0040.
REQ-029 take_jump=1, jump_target=0x8000_0102 -> trap cause 0, pc=mtvec; target 0x8000_0200 -> fetch 0x8000_0200.
REQ-030 MC_SEQUENCER_IRQ_EN defined, irq pulsed during WAIT_ALU -> trap in NEXT_PC, cause 11, trap_is_irq=1; undefined -> normal pc+4.
REQ-031 rst asserted during MEM stall -> next cycle FETCH, no rf_we, no trap, mem_addr 0x8000_0000.
